// File: rtl/cpu_pkg.sv
// Shared encodings, FSM state type and decode helpers for the multicycle RV32I-subset core.
package cpu_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam logic [31:0] ECALL = 32'h0000_0073;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  // Legal means supported encoding and, on RV32E, no used register field above x15.
  function automatic logic insn_legal(input logic [31:0] ir, input logic rv32e);
    logic ok;
    logic use_rd;
    logic use_rs1;
    logic use_rs2;
    ok      = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (ir[6:0])
      OP: begin
        ok      = (ir[14:12] == F3_ADD) && (ir[31:25] == F7_ADD || ir[31:25] == F7_SUB);
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_IMM: begin
        ok      = (ir[14:12] == F3_ADD);
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      BRANCH: begin
        ok      = (ir[14:12] == F3_BEQ) || (ir[14:12] == F3_BNE);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      LOAD: begin
        ok      = (ir[14:12] == F3_LW);
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      STORE: begin
        ok      = (ir[14:12] == F3_SW);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      SYSTEM:  ok = (ir == ECALL);
      default: ok = 1'b0;
    endcase
    if (rv32e && ((use_rd && ir[11]) || (use_rs1 && ir[19]) || (use_rs2 && ir[24])))
      ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [31:0] imm_of(input logic [31:0] ir);
    case (ir[6:0])
      STORE:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
      BRANCH:  return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      default: return {{20{ir[31]}}, ir[31:20]};
    endcase
  endfunction

endpackage

// File: rtl/cpu_mem_if.sv
// Unified instruction/data memory port with a req/ready handshake.
interface cpu_mem_if #(parameter int A_WIDTH = 32) ();
  logic               mem_req;
  logic               mem_we;
  logic [A_WIDTH-1:0] mem_addr;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata;
  logic               mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/regfile_n.sv
// Register file: two asynchronous read ports, one synchronous write port, x0 hardwired to zero.
module regfile_n #(
  parameter  int NREGS = 32,
  localparam int IW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] ra1,
  input  logic [IW-1:0] ra2,
  output logic [31:0]   rd1,
  output logic [31:0]   rd2,
  input  logic          we,
  input  logic [IW-1:0] wa,
  input  logic [31:0]   wd,
  output logic [31:0]   a0
);

  logic [31:0] regs [NREGS];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs[gi] = '0;
      end else begin : g_live
        logic [31:0] r_reg;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst)
            r_reg <= '0;
          else if (we && wa == IW'(gi))
            r_reg <= wd;
        end
        assign regs[gi] = r_reg;
      end
    end
  endgenerate

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];
  assign a0  = regs[10];

endmodule

// File: rtl/cpu_multicycle.sv
// Multicycle RV32I-subset core (ADD/SUB/ADDI/BEQ/BNE/LW/SW/ECALL) on one shared memory port.
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter int                 A_WIDTH  = 32,
  parameter int                 NREGS    = 32,
  parameter logic [A_WIDTH-1:0] RESET_PC = '0
) (
  input  logic        clk,
  input  logic        rst,
  cpu_mem_if.master   mem,
  output logic [31:0] a0,
  output logic        halted,
  output logic        illegal
);

  localparam int   IW    = $clog2(NREGS);
  localparam logic RV32E = (NREGS == 16);

  state_t             state_reg;
  logic [A_WIDTH-1:0] pc_reg;
  logic [31:0]        ir_reg, a_reg, b_reg, imm_reg, res_reg;
  logic               mem_req_reg, mem_we_reg;
  logic [A_WIDTH-1:0] mem_addr_reg;
  logic [31:0]        mem_wdata_reg;
  logic               halted_reg, illegal_reg;

  logic [31:0]        rd1, rd2, ea;
  logic [A_WIDTH-1:0] pc_plus4, br_target, br_next;
  logic               legal, br_taken;

  regfile_n #(.NREGS(NREGS)) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (ir_reg[15 +: IW]),
    .ra2 (ir_reg[20 +: IW]),
    .rd1 (rd1),
    .rd2 (rd2),
    .we  (state_reg == WB),
    .wa  (ir_reg[7 +: IW]),
    .wd  (res_reg),
    .a0  (a0)
  );

  assign legal     = insn_legal(ir_reg, RV32E);
  assign pc_plus4  = pc_reg + A_WIDTH'(4);
  assign br_target = pc_reg + imm_reg[A_WIDTH-1:0];
  assign br_taken  = (ir_reg[14:12] == F3_BNE) ? (a_reg != b_reg) : (a_reg == b_reg);
  assign br_next   = br_taken ? br_target : pc_plus4;
  assign ea        = a_reg + imm_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      pc_reg        <= RESET_PC;
      ir_reg        <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      imm_reg       <= '0;
      res_reg       <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      halted_reg    <= 1'b0;
      illegal_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg    <= FETCH;
          mem_req_reg  <= 1'b1;
          mem_we_reg   <= 1'b0;
          mem_addr_reg <= pc_reg;
        end
        FETCH: if (mem.mem_ready) begin
          ir_reg      <= mem.mem_rdata;
          mem_req_reg <= 1'b0;
          state_reg   <= DECODE;
        end
        DECODE: begin
          a_reg     <= rd1;
          b_reg     <= rd2;
          imm_reg   <= imm_of(ir_reg);
          state_reg <= EXEC;
        end
        EXEC: begin
          // Every fault leaves pc_reg pointing at the offending instruction.
          if (!legal) begin
            state_reg   <= HALT;
            halted_reg  <= 1'b1;
            illegal_reg <= 1'b1;
          end else begin
            case (ir_reg[6:0])
              OP: begin
                res_reg   <= (ir_reg[31:25] == F7_SUB) ? a_reg - b_reg : a_reg + b_reg;
                state_reg <= WB;
              end
              OP_IMM: begin
                res_reg   <= a_reg + imm_reg;
                state_reg <= WB;
              end
              BRANCH: begin
                if (br_taken && br_target[1:0] != 2'b00) begin
                  state_reg   <= HALT;
                  halted_reg  <= 1'b1;
                  illegal_reg <= 1'b1;
                end else begin
                  pc_reg       <= br_next;
                  mem_addr_reg <= br_next;
                  mem_we_reg   <= 1'b0;
                  mem_req_reg  <= 1'b1;
                  state_reg    <= FETCH;
                end
              end
              LOAD, STORE: begin
                if (ea[1:0] != 2'b00) begin
                  state_reg   <= HALT;
                  halted_reg  <= 1'b1;
                  illegal_reg <= 1'b1;
                end else begin
                  mem_req_reg   <= 1'b1;
                  mem_we_reg    <= (ir_reg[6:0] == STORE);
                  mem_addr_reg  <= ea[A_WIDTH-1:0];
                  mem_wdata_reg <= b_reg;
                  state_reg     <= MEM;
                end
              end
              SYSTEM: begin
                state_reg  <= HALT;
                halted_reg <= 1'b1;
              end
              default: begin
                state_reg   <= HALT;
                halted_reg  <= 1'b1;
                illegal_reg <= 1'b1;
              end
            endcase
          end
        end
        MEM: if (mem.mem_ready) begin
          if (mem_we_reg) begin
            // Store retires straight into the next fetch; mem_req stays high.
            pc_reg       <= pc_plus4;
            mem_addr_reg <= pc_plus4;
            mem_we_reg   <= 1'b0;
            state_reg    <= FETCH;
          end else begin
            res_reg     <= mem.mem_rdata;
            mem_req_reg <= 1'b0;
            state_reg   <= WB;
          end
        end
        WB: begin
          pc_reg       <= pc_plus4;
          mem_addr_reg <= pc_plus4;
          mem_req_reg  <= 1'b1;
          state_reg    <= FETCH;
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req   = mem_req_reg;
  assign mem.mem_we    = mem_we_reg;
  assign mem.mem_addr  = mem_addr_reg;
  assign mem.mem_wdata = mem_wdata_reg;
  assign halted        = halted_reg;
  assign illegal       = illegal_reg;

endmodule
